// File: rtl/clk_switch_ctrl_if.sv
// Request/ack bundle between clock-switch requesters and the switch controller.
// The master side raises requests; the slave side arbitrates and drives sel.
interface clk_switch_ctrl_if;
    logic       req_a;
    logic       req_b;
    logic       tgt_a;
    logic       tgt_b;
    logic       ack_a;
    logic       ack_b;
    logic       sel;
    logic       busy;
    logic [7:0] sw_cnt;

    modport master (
        output req_a, req_b, tgt_a, tgt_b,
        input  ack_a, ack_b, sel, busy, sw_cnt
    );

    modport slave (
        input  req_a, req_b, tgt_a, tgt_b,
        output ack_a, ack_b, sel, busy, sw_cnt
    );
endinterface

// File: rtl/clk_switch_ctrl.sv
// Round-robin clock-source switch controller: drives a registered select,
// holds it through a settle window, acks the winner, then dwells.
module clk_switch_ctrl #(
    parameter int   SETTLE_CYC = 4,
    parameter int   DWELL_CYC  = 8,
    parameter logic SEL_RST    = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    clk_switch_ctrl_if.slave  bus
);

    localparam int MAXC = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic          busy_q, busy_d;
    logic [7:0]    sw_cnt_q, sw_cnt_d;
    logic          ptr_q, ptr_d;
    logic          who_q, who_d;

    logic va;
    logic vb;
    logic win;
    logic wtgt;

    // A requester whose ack is out this cycle is still holding a served request.
    assign va   = bus.req_a & ~ack_a_q;
    assign vb   = bus.req_b & ~ack_b_q;
    assign win  = (va & vb) ? ptr_q : vb;
    assign wtgt = win ? bus.tgt_b : bus.tgt_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= SEL_RST;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            busy_q   <= 1'b0;
            sw_cnt_q <= '0;
            ptr_q    <= 1'b0;
            who_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            busy_q   <= busy_d;
            sw_cnt_q <= sw_cnt_d;
            ptr_q    <= ptr_d;
            who_q    <= who_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        sw_cnt_d = sw_cnt_q;
        ptr_d    = ptr_q;
        who_d    = who_q;

        unique case (state_q)
            IDLE: begin
                if (va | vb) begin
                    who_d = win;
                    ptr_d = ~win;
                    if (wtgt == sel_q) begin
                        ack_a_d = ~win;
                        ack_b_d = win;
                    end else begin
                        sel_d   = wtgt;
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    state_d  = DWELL;
                    cnt_d    = '0;
                    ack_a_d  = ~who_q;
                    ack_b_d  = who_q;
                    sw_cnt_d = sw_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DWELL: begin
                if (cnt_q == CW'(DWELL_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.ack_a  = ack_a_q;
    assign bus.ack_b  = ack_b_q;
    assign bus.sel    = sel_q;
    assign bus.busy   = busy_q;
    assign bus.sw_cnt = sw_cnt_q;

endmodule
